// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add WIDTH x WIDTH unsigned multiplier issuing a one-cycle RegisterFile write.
// Define SEQ_MUL_HIGH_EN to add HighSel, which returns the upper product half (UMULH) instead of the lower (MUL).
module seq_multiplier #(
  parameter int WIDTH      = 64,
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      BusA,
  input  logic [WIDTH-1:0]      BusB,
  input  logic [REG_ADDR_W-1:0] RdIn,
`ifdef SEQ_MUL_HIGH_EN
  input  logic                  HighSel,
`endif
  output logic                  Busy,
  output logic                  Done,
  output logic [WIDTH-1:0]      BusW,
  output logic [REG_ADDR_W-1:0] RW,
  output logic                  RegWr
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, WRITE} state_t;
  state_t                  state_q, state_d;
  logic [2*WIDTH-1:0]      mcand_q, mcand_d, prod_q, prod_d;
  logic [WIDTH-1:0]        mplier_q, mplier_d, busw_q, busw_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0]   dest_q, dest_d, rw_q, rw_d;
  logic                    hi_q, hi_d, hi_in;
  logic                    start_ok, run, last;
`ifdef SEQ_MUL_HIGH_EN
  assign hi_in = HighSel;
`else
  assign hi_in = 1'b0;
`endif
  // Result and destination are latched on the final RUN edge so they hold after WRITE.
  always_comb begin
    start_ok = state_q == IDLE && Start;
    run      = state_q == RUN;
    last     = run && cnt_q == CW'(WIDTH - 1);
    state_d  = start_ok ? RUN : last ? WRITE : state_q == WRITE ? IDLE : state_q;
    mcand_d  = start_ok ? {{WIDTH{1'b0}}, BusA} : run ? mcand_q << 1 : mcand_q;
    mplier_d = start_ok ? BusB : run ? mplier_q >> 1 : mplier_q;
    prod_d   = start_ok ? '0 : (run && mplier_q[0]) ? prod_q + mcand_q : prod_q;
    cnt_d    = start_ok ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    dest_d   = start_ok ? RdIn : dest_q;
    hi_d     = start_ok ? hi_in : hi_q;
    busw_d   = last ? (hi_q ? prod_d[2*WIDTH-1:WIDTH] : prod_d[WIDTH-1:0]) : busw_q;
    rw_d     = last ? dest_q : rw_q;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      dest_q   <= '0;
      hi_q     <= 1'b0;
      busw_q   <= '0;
      rw_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      dest_q   <= dest_d;
      hi_q     <= hi_d;
      busw_q   <= busw_d;
      rw_q     <= rw_d;
    end
  end
  assign Busy  = state_q != IDLE;
  assign Done  = state_q == WRITE;
  assign BusW  = busw_q;
  assign RW    = rw_q;
  assign RegWr = Done && rw_q != REG_ADDR_W'(ZERO_REG);
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: vector table, corner sequences and random operands checked against a 128-bit product model.
module tb_seq_multiplier;
`ifdef SEQ_MUL_HIGH_EN
  localparam bit HIGH = 1'b1;
`else
  localparam bit HIGH = 1'b0;
`endif
  localparam logic [63:0] MAX = 64'hFFFF_FFFF_FFFF_FFFF;
  logic        Clk = 1'b0, Reset = 1'b1, Start = 1'b0;
  logic [63:0] BusA = '0, BusB = '0;
  logic [4:0]  RdIn = '0;
`ifdef SEQ_MUL_HIGH_EN
  logic        HighSel = 1'b0;
`endif
  logic        Busy, Done, RegWr;
  logic [63:0] BusW;
  logic [4:0]  RW;
  logic [63:0] rf [32];
  int total = 0, bad = 0;

  always #5 Clk = ~Clk;

  seq_multiplier dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BusA(BusA), .BusB(BusB), .RdIn(RdIn),
`ifdef SEQ_MUL_HIGH_EN
    .HighSel(HighSel),
`endif
    .Busy(Busy), .Done(Done), .BusW(BusW), .RW(RW), .RegWr(RegWr)
  );

  always @(posedge Clk) if (RegWr) rf[RW] <= BusW;

  function automatic logic [63:0] rd_rf(input logic [4:0] r);
    return r == 5'd31 ? 64'd0 : rf[r];
  endfunction

  function automatic logic [63:0] model(input logic [63:0] a, b, input bit hs);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    return (HIGH && hs) ? p[127:64] : p[63:0];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [63:0] a, b, input logic [4:0] rd, input bit hs,
                        input logic [63:0] exp_w, input bit exp_wr, input int inj0, input int inj1);
    int busy_n = 0, done_n = 0, done_j = -1, wr_n = 0;
    logic [63:0] w = '0, old5;
    logic [4:0]  rw = '0;
    old5 = rf[5];
    @(negedge Clk);
    Start = 1'b1; BusA = a; BusB = b; RdIn = rd;
`ifdef SEQ_MUL_HIGH_EN
    HighSel = hs;
`endif
    @(posedge Clk);
    #1;
    Start = 1'b0; BusA = ~a; BusB = ~b; RdIn = ~rd;
`ifdef SEQ_MUL_HIGH_EN
    HighSel = ~hs;
`endif
    // j counts cycles after the accepting edge; WRITE is expected at j=64
    for (int j = 0; j < 70; j++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (j == inj0 || j == inj1) begin
        Start = 1'b1; BusA = 64'd2; BusB = 64'd2; RdIn = 5'd5;
      end
      busy_n += int'(Busy);
      wr_n   += int'(RegWr);
      if (Done) begin
        done_n++; done_j = j; w = BusW; rw = RW;
      end
      if (j == 66) chk("busw_hold", BusW, exp_w);
    end
    chk("busy_cycles", busy_n, 65);
    chk("done_count", done_n, 1);
    chk("done_cycle", done_j, 64);
    chk("busw", w, exp_w);
    chk("rw", rw, rd);
    chk("regwr_count", wr_n, exp_wr ? 1 : 0);
    if (rd != 5'd31) chk("rf_read", rd_rf(rd), exp_w);
    if (inj0 >= 0 && rd != 5'd5) chk("rf5_untouched", rf[5], old5);
  endtask

  typedef struct {
    logic [63:0] a, b;
    logic [4:0]  rd;
    bit          hs;
    logic [63:0] w;
    bit          wr;
  } vec_t;
  vec_t tab[7];

  initial begin
    logic [63:0] a, b, old12;
    logic [4:0]  rd;
    bit          hs;
    int          wr_n;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    tab[0] = '{64'd3, 64'd5, 5'd10, 1'b0, 64'hF, 1'b1};
    tab[1] = '{MAX, 64'd2, 5'd4, 1'b1, HIGH ? 64'h1 : 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
    tab[2] = '{64'd7, 64'd9, 5'd31, 1'b0, 64'd63, 1'b0};
    tab[3] = '{64'd0, 64'd123, 5'd1, 1'b0, 64'd0, 1'b1};
    tab[4] = '{MAX, MAX, 5'd7, 1'b0, 64'h1, 1'b1};
    tab[5] = '{MAX, MAX, 5'd8, 1'b1, HIGH ? 64'hFFFF_FFFF_FFFF_FFFE : 64'h1, 1'b1};
    tab[6] = '{64'h1_0000_0000, 64'h1_0000_0000, 5'd9, 1'b0, 64'd0, 1'b1};
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("idle_flags", {Busy, Done, RegWr}, 3'b000);
      chk("idle_bus", {BusW, RW}, 69'd0);
    end
    for (int i = 0; i < 7; i++)
      run_op(tab[i].a, tab[i].b, tab[i].rd, tab[i].hs, tab[i].w, tab[i].wr, -1, -1);
    run_op(64'd3, 64'd5, 5'd10, 1'b0, 64'hF, 1'b1, 20, 64);
    old12 = rf[12];
    @(negedge Clk);
    Start = 1'b1; BusA = 64'd77; BusB = 64'd99; RdIn = 5'd12;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (30) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("reset_busy", Busy, 1'b0);
    chk("reset_done", Done, 1'b0);
    chk("reset_busw", BusW, 64'd0);
    Reset = 1'b0;
    wr_n = 0;
    for (int j = 0; j < 70; j++) begin
      @(negedge Clk);
      wr_n += int'(RegWr) + int'(Busy);
    end
    chk("reset_no_activity", wr_n, 0);
    chk("reset_rf12", rf[12], old12);
    run_op(64'd0, 64'd123, 5'd1, 1'b0, 64'd0, 1'b1, -1, -1);
    for (int i = 0; i < 12; i++) begin
      a  = {$urandom(), $urandom()};
      b  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 255)) : {$urandom(), $urandom()};
      rd = 5'($urandom_range(0, 31));
      hs = 1'($urandom_range(0, 1));
      run_op(a, b, rd, hs, model(a, b, hs), rd != 5'd31, -1, -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
